approx_err_evaluator: RTL and testbench

- Sequential checker that sits opposite a generated approximate 2-operand multiplier.
- Sweeps every input vector into the circuit under test (CUT) and computes the exact product internally.
- Accumulates the worst-case absolute error (WCE), the error count, and the first vector that hits the WCE.
- Reports pass/fail against the error threshold used for synthesis. Used in hardware-in-loop validation of approximate circuit outputs.

---
 rtl/approx_eval_pkg.sv | 21 ++
 rtl/approx_eval_align.sv | 46 ++++
 rtl/approx_err_evaluator.sv | 153 +++++++++++++++
 tb/tb_approx_err_evaluator.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/approx_eval_pkg.sv
// Shared types and helpers for the approximate-multiplier error evaluator.
// Default-geometry constants; the top re-derives its own from its parameters.
package approx_eval_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int IN_W_DEF = 4;
    localparam int N_VEC    = 2 ** IN_W_DEF;
    localparam int OPW      = IN_W_DEF / 2;

    // Operands are zero-extended by the caller, so an unsigned compare-and-subtract is exact.
    function automatic logic [31:0] abs_diff(input logic [31:0] exact, input logic [31:0] approx);
        return (exact >= approx) ? (exact - approx) : (approx - exact);
    endfunction

endpackage

// File: rtl/approx_eval_align.sv
// LAT-deep (vec, valid) delay line lining up driven vectors with CUT results.
// Collapses to plain wires for a combinational CUT.
module approx_eval_align #(
    parameter int W   = 4,
    parameter int LAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] vec_in,
    input  logic         valid_in,
    output logic [W-1:0] vec_out,
    output logic         valid_out
);

    generate
        if (LAT == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign vec_out        = vec_in;
            assign valid_out      = valid_in;
        end else begin : g_pipe
            logic [W-1:0] vec_q   [LAT];
            logic [LAT-1:0] valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) begin
                        vec_q[i] <= '0;
                    end
                    valid_q <= '0;
                end else begin
                    vec_q[0]   <= vec_in;
                    valid_q[0] <= valid_in;
                    for (int i = 1; i < LAT; i++) begin
                        vec_q[i]   <= vec_q[i-1];
                        valid_q[i] <= valid_q[i-1];
                    end
                end
            end

            assign vec_out   = vec_q[LAT-1];
            assign valid_out = valid_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/approx_err_evaluator.sv
// Exhaustive sweep of a 2-operand approximate multiplier, tracking worst-case error,
// error count and the first vector reaching the worst case.
//   state    | meaning
//   ST_IDLE  | after reset, waiting for start
//   ST_SWEEP | driving vectors 0 .. 2^IN_W-1, one per cycle
//   ST_DRAIN | LAT cycles flushing the CUT pipeline
//   ST_DONE  | results and pass held until the next start
module approx_err_evaluator
    import approx_eval_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 4,
    parameter int ET    = 4,
    parameter int LAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [IN_W-1:0]  cut_in,
    input  logic [OUT_W-1:0] cut_out,
    output logic             busy,
    output logic             done,
    output logic [IN_W-1:0]  max_err,
    output logic [IN_W:0]    err_count,
    output logic [IN_W-1:0]  wce_vec,
    output logic             pass
);

    localparam int              OPW_L    = IN_W / 2;
    localparam int              DW       = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [IN_W-1:0] LAST_VEC = '1;
    localparam logic [31:0]     ET_U     = 32'(ET);

    state_e            state_q, state_d;
    logic [IN_W-1:0]   vec_q, vec_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [IN_W-1:0]   max_err_q, max_err_d;
    logic [IN_W:0]     err_count_q, err_count_d;
    logic [IN_W-1:0]   wce_vec_q, wce_vec_d;

    logic [IN_W-1:0]   al_vec;
    logic              al_valid;
    logic [31:0]       exact32;
    logic [31:0]       err32;

    approx_eval_align #(.W(IN_W), .LAT(LAT)) u_align (
        .clk       (clk),
        .rst       (rst),
        .vec_in    (vec_q),
        .valid_in  (state_q == ST_SWEEP),
        .vec_out   (al_vec),
        .valid_out (al_valid)
    );

    assign exact32 = 32'(al_vec[OPW_L-1:0]) * 32'(al_vec[IN_W-1:OPW_L]);
    assign err32   = abs_diff(exact32, 32'(cut_out));

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        drain_d     = drain_q;
        pass_d      = pass_q;
        max_err_d   = max_err_q;
        err_count_d = err_count_q;
        wce_vec_d   = wce_vec_q;

        // Strict greater-than keeps the earliest vector on ties.
        if (al_valid) begin
            if (err32 != 32'd0) begin
                err_count_d = err_count_q + (IN_W+1)'(1);
            end
            if (err32 > 32'(max_err_q)) begin
                max_err_d = err32[IN_W-1:0];
                wce_vec_d = al_vec;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_SWEEP;
                    vec_d       = '0;
                    max_err_d   = '0;
                    err_count_d = '0;
                    wce_vec_d   = '0;
                    pass_d      = 1'b0;
                end
            end
            ST_SWEEP: begin
                if (vec_q == LAST_VEC) begin
                    if (LAT == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                        drain_d = DW'(LAT - 1);
                    end
                end else begin
                    vec_d = vec_q + IN_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SWEEP) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            pass_d = (32'(max_err_d) <= ET_U);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vec_q       <= '0;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            max_err_q   <= '0;
            err_count_q <= '0;
            wce_vec_q   <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            drain_q     <= drain_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            max_err_q   <= max_err_d;
            err_count_q <= err_count_d;
            wce_vec_q   <= wce_vec_d;
        end
    end

    assign cut_in    = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign max_err   = max_err_q;
    assign err_count = err_count_q;
    assign wce_vec   = wce_vec_q;

endmodule

// File: tb/tb_approx_err_evaluator.sv
// Bench for approx_err_evaluator: three instances (LAT 0, 1, 2) share a CUT lookup table;
// a prefix model of the sweep is checked every cycle, plus hand-computed end results.
module tb_approx_err_evaluator;

    logic clk = 1'b0;
    logic rst;
    logic start;
    always #5 clk = ~clk;

    logic [3:0] ci0, ci1, ci2, co0, co1, co2;
    logic [3:0] me0, me1, me2, wv0, wv1, wv2;
    logic [4:0] ec0, ec1, ec2;
    logic       b0, b1, b2, d0, d1, d2, p0, p1, p2;

    logic [3:0] tbl [16];
    logic [3:0] s1a, s2a, s1b, s2b;

    // CUT: table lookup, combinational for dut0, two register stages for dut1/dut2.
    assign co0 = tbl[ci0];
    always @(posedge clk) begin
        s1a <= tbl[ci1];
        s2a <= s1a;
        s1b <= tbl[ci2];
        s2b <= s1b;
    end
    assign co1 = s2a;
    assign co2 = s2b;

    approx_err_evaluator #(.IN_W(4), .OUT_W(4), .ET(4), .LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .cut_in(ci0), .cut_out(co0), .busy(b0),
        .done(d0), .max_err(me0), .err_count(ec0), .wce_vec(wv0), .pass(p0));
    approx_err_evaluator #(.IN_W(4), .OUT_W(4), .ET(4), .LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .cut_in(ci1), .cut_out(co1), .busy(b1),
        .done(d1), .max_err(me1), .err_count(ec1), .wce_vec(wv1), .pass(p1));
    approx_err_evaluator #(.IN_W(4), .OUT_W(4), .ET(4), .LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .cut_in(ci2), .cut_out(co2), .busy(b2),
        .done(d2), .max_err(me2), .err_count(ec2), .wce_vec(wv2), .pass(p2));

    int errors = 0;
    int checks = 0;
    int n_edge = 0;
    bit chk_on = 1'b0;
    int pre_max [17];
    int pre_cnt [17];
    int pre_wce [17];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected results after the first k vectors of a sweep, straight from the error rules.
    function automatic void build_model();
        int m = 0;
        int c = 0;
        int w = 0;
        pre_max[0] = 0;
        pre_cnt[0] = 0;
        pre_wce[0] = 0;
        for (int v = 0; v < 16; v++) begin
            int exact = (v % 4) * (v / 4);
            int e = exact - int'(tbl[v]);
            if (e < 0) e = -e;
            if (e != 0) c++;
            if (e > m) begin
                m = e;
                w = v;
            end
            pre_max[v+1] = m;
            pre_cnt[v+1] = c;
            pre_wce[v+1] = w;
        end
    endfunction

    task automatic check_dut(input string nm, input int lat, input logic b, input logic d,
                             input logic [3:0] me, input logic [4:0] ec, input logic [3:0] wv,
                             input logic p);
        int k = n_edge - lat;
        bit fin = (n_edge >= 16 + lat);
        if (k < 0) k = 0;
        if (k > 16) k = 16;
        chk({nm, ".busy"}, int'(b), int'(!fin));
        chk({nm, ".done"}, int'(d), int'(fin));
        chk({nm, ".max_err"}, int'(me), pre_max[k]);
        chk({nm, ".err_count"}, int'(ec), pre_cnt[k]);
        chk({nm, ".wce_vec"}, int'(wv), pre_wce[k]);
        if (fin) chk({nm, ".pass"}, int'(p), int'(pre_max[16] <= 4));
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check_dut("d0", 0, b0, d0, me0, ec0, wv0, p0);
            check_dut("d2", 2, b2, d2, me2, ec2, wv2, p2);
        end
    end

    task automatic run_sweep(input bit extra_start);
        int guard = 0;
        build_model();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        n_edge = 0;
        chk_on = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (guard < 40) begin
            @(posedge clk);
            n_edge++;
            guard++;
            @(negedge clk);
            start = extra_start && (n_edge == 5);
            if (d0 && d1 && d2) break;
        end
        start = 1'b0;
        if (guard >= 40) chk("sweep_timeout", 0, 1);
        @(posedge clk);
        chk_on = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string nm);
        chk({nm, ".cut_in"}, int'(ci0), 0);
        chk({nm, ".busy"}, int'(b0), 0);
        chk({nm, ".done"}, int'(d0), 0);
        chk({nm, ".max_err"}, int'(me0), 0);
        chk({nm, ".err_count"}, int'(ec0), 0);
        chk({nm, ".wce_vec"}, int'(wv0), 0);
        chk({nm, ".pass"}, int'(p0), 0);
        chk({nm, ".busy2"}, int'(b2), 0);
        chk({nm, ".err_count2"}, int'(ec2), 0);
    endtask

    task automatic fill_exact();
        for (int v = 0; v < 16; v++) tbl[v] = 4'((v % 4) * (v / 4));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        fill_exact();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;

        // Exact CUT: no error anywhere; LAT=1 against a 2-cycle CUT must see errors.
        run_sweep(1'b0);
        chk("exact.max_err", int'(me0), 0);
        chk("exact.err_count", int'(ec0), 0);
        chk("exact.wce_vec", int'(wv0), 0);
        chk("exact.pass", int'(p0), 1);
        chk("exact.lat2_pass", int'(p2), 1);
        chk("exact.misalign_nonzero", int'(me1 != 4'd0), 1);

        // CUT tied to zero.
        for (int v = 0; v < 16; v++) tbl[v] = 4'd0;
        run_sweep(1'b0);
        chk("zero.max_err", int'(me0), 9);
        chk("zero.err_count", int'(ec0), 9);
        chk("zero.wce_vec", int'(wv0), 15);
        chk("zero.pass", int'(p0), 0);

        // Off-by-one CUT, with a stray start mid-sweep, then rerun from DONE.
        for (int v = 0; v < 16; v++) tbl[v] = 4'(((v % 4) * (v / 4) + 1) % 16);
        for (int r = 0; r < 2; r++) begin
            run_sweep(r == 0);
            chk("plus1.err_count", int'(ec0), 16);
            chk("plus1.max_err", int'(me0), 1);
            chk("plus1.wce_vec", int'(wv0), 0);
            chk("plus1.pass", int'(p0), 1);
            chk("plus1.lat2_err_count", int'(ec2), 16);
        end

        // Asynchronous reset at vector 7 aborts the sweep.
        fill_exact();
        tbl[3] = 4'd9;
        build_model();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        n_edge = 0;
        chk_on = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) begin
            @(posedge clk);
            n_edge++;
        end
        @(posedge clk);
        n_edge++;
        chk_on = 1'b0;
        @(negedge clk);
        chk("abort.cut_in_before", int'(ci0), 7);
        #2 rst = 1'b1;
        #1 check_zero_outputs("abort");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_sweep(1'b0);
        chk("after_abort.max_err", int'(me0), 9);
        chk("after_abort.err_count", int'(ec0), 1);
        chk("after_abort.wce_vec", int'(wv0), 3);
        chk("after_abort.pass", int'(p0), 0);

        // Randomized CUT tables: fully random or exact with sparse perturbations.
        for (int r = 0; r < 6; r++) begin
            for (int v = 0; v < 16; v++) begin
                if (r % 2 == 0) tbl[v] = 4'($urandom_range(0, 15));
                else if ($urandom_range(0, 3) == 0) tbl[v] = 4'($urandom_range(0, 15));
                else tbl[v] = 4'((v % 4) * (v / 4));
            end
            run_sweep(r == 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
